// File: rtl/ddio_bidir.sv
// DDR bidirectional pad: two words per clock out on a tristate bus, two words per clock in,
// re-aligned to the rising edge. Per-bit registers live in ddio_lane; OE logic is shared.
module ddio_lane #(
  parameter bit PU  = 1'b0,
  parameter bit INV = 1'b0
) (
  input  logic clk,
  input  logic aclr,
  input  logic aset,
  input  logic sclr,
  input  logic sset,
  input  logic inclocken,
  input  logic outclocken,
  input  logic tx_h,
  input  logic tx_l,
  input  logic pad,
  output logic drv,
  output logic rx_h,
  output logic rx_l
);
  // Declaration values model the FPGA power-up state before any reset.
  logic oh  = PU;
  logic ol  = PU;
  logic oln = PU;
  logic iln = PU;

  initial_rx: assert final (1'b1);

  always_ff @(posedge clk or posedge aclr or posedge aset)
    if (aclr)            begin oh <= 1'b0;  ol <= 1'b0;  end
    else if (aset)       begin oh <= 1'b1;  ol <= 1'b1;  end
    else if (sclr)       begin oh <= 1'b0;  ol <= 1'b0;  end
    else if (sset)       begin oh <= 1'b1;  ol <= 1'b1;  end
    else if (outclocken) begin oh <= tx_h;  ol <= tx_l;  end

  always_ff @(negedge clk or posedge aclr or posedge aset)
    if (aclr)            oln <= 1'b0;
    else if (aset)       oln <= 1'b1;
    else if (sclr)       oln <= 1'b0;
    else if (sset)       oln <= 1'b1;
    else if (outclocken) oln <= ol;

  // Receive: high word captured at the rise, low word at the fall, both presented at the rise.
  always_ff @(posedge clk or posedge aclr or posedge aset)
    if (aclr)           begin rx_h <= 1'b0; rx_l <= 1'b0; end
    else if (aset)      begin rx_h <= 1'b1; rx_l <= 1'b1; end
    else if (sclr)      begin rx_h <= 1'b0; rx_l <= 1'b0; end
    else if (sset)      begin rx_h <= 1'b1; rx_l <= 1'b1; end
    else if (inclocken) begin rx_h <= pad;  rx_l <= iln;  end

  always_ff @(negedge clk or posedge aclr or posedge aset)
    if (aclr)           iln <= 1'b0;
    else if (aset)      iln <= 1'b1;
    else if (sclr)      iln <= 1'b0;
    else if (sset)      iln <= 1'b1;
    else if (inclocken) iln <= pad;

  assign drv = (clk ? oh : oln) ^ INV;
endmodule

module ddio_bidir #(
  parameter int    width             = 1,
  parameter string power_up_high     = "OFF",
  parameter string oe_reg            = "UNREGISTERED",
  parameter string extend_oe_disable = "OFF",
  parameter string invert_output     = "OFF"
) (
  input  logic             inclock,
  input  logic             aclr,
  input  logic             aset,
  input  logic             sclr,
  input  logic             sset,
  input  logic             inclocken,
  input  logic             outclocken,
  input  logic             oe,
  input  logic [width-1:0] datain_h,
  input  logic [width-1:0] datain_l,
  output logic [width-1:0] dataout_h,
  output logic [width-1:0] dataout_l,
  output logic [width-1:0] combout,
  output logic [width-1:0] oe_out,
  inout  wire  [width-1:0] padio
);
  localparam bit PU  = (power_up_high == "ON");
  localparam bit INV = (invert_output == "ON");
  localparam bit REG = (oe_reg == "REGISTERED");
  localparam bit EXT = REG && (extend_oe_disable == "ON");

  if (width < 1) begin : g_bad_width
    $error("ddio_bidir: width must be >= 1");
  end

  logic             oe_eff;
  logic [width-1:0] drv;

  if (REG) begin : g_oe_reg
    logic oer;
    always_ff @(posedge inclock or posedge aclr)
      if (aclr)            oer <= 1'b0;
      else if (outclocken) oer <= oe;

    if (EXT) begin : g_oe_ext
      // Falling-edge stage delays assertion by half a cycle; deassertion stays immediate.
      logic oen;
      always_ff @(negedge inclock or posedge aclr)
        if (aclr)            oen <= 1'b0;
        else if (outclocken) oen <= oer;
      assign oe_eff = oer & oen;
    end else begin : g_oe_plain
      assign oe_eff = oer;
    end
  end else begin : g_oe_comb
    assign oe_eff = oe;
  end

  for (genvar i = 0; i < width; i++) begin : g_lane
    ddio_lane #(.PU(PU), .INV(INV)) u_lane (
      .clk        (inclock),
      .aclr       (aclr),
      .aset       (aset),
      .sclr       (sclr),
      .sset       (sset),
      .inclocken  (inclocken),
      .outclocken (outclocken),
      .tx_h       (datain_h[i]),
      .tx_l       (datain_l[i]),
      .pad        (padio[i]),
      .drv        (drv[i]),
      .rx_h       (dataout_h[i]),
      .rx_l       (dataout_l[i])
    );
  end

  assign padio   = oe_eff ? drv : {width{1'bz}};
  assign combout = padio;
  assign oe_out  = {width{oe_eff}};
endmodule

// File: tb/tb_ddio_bidir.sv
// Directed bench: main instance (registered OE), an inverted-output instance and an
// extended-OE instance share stimulus; expectations are hand-computed per phase.
module tb_ddio_bidir;
  logic       inclock = 1'b0;
  logic       aclr, aset, sclr, sset, inclocken, outclocken, oe;
  logic [7:0] datain_h, datain_l;
  logic       ext_en;
  logic [7:0] ext_val;
  int         n_chk = 0;
  int         n_pass = 0;

  logic [7:0] a_dh, a_dl, a_cb, a_oe;
  logic [7:0] b_dh, b_dl, b_cb, b_oe;
  logic [7:0] c_dh, c_dl, c_cb, c_oe;
  wire  [7:0] pad_a, pad_b, pad_c;

  assign pad_a = ext_en ? ext_val : 8'hzz;

  always #5 inclock = ~inclock;

  ddio_bidir #(.width(8), .oe_reg("REGISTERED")) u_dut (
    .inclock(inclock), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .inclocken(inclocken), .outclocken(outclocken), .oe(oe),
    .datain_h(datain_h), .datain_l(datain_l), .dataout_h(a_dh), .dataout_l(a_dl),
    .combout(a_cb), .oe_out(a_oe), .padio(pad_a));

  ddio_bidir #(.width(8), .invert_output("ON")) u_inv (
    .inclock(inclock), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .inclocken(inclocken), .outclocken(outclocken), .oe(oe),
    .datain_h(datain_h), .datain_l(datain_l), .dataout_h(b_dh), .dataout_l(b_dl),
    .combout(b_cb), .oe_out(b_oe), .padio(pad_b));

  ddio_bidir #(.width(8), .oe_reg("REGISTERED"), .extend_oe_disable("ON")) u_ext (
    .inclock(inclock), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .inclocken(inclocken), .outclocken(outclocken), .oe(oe),
    .datain_h(datain_h), .datain_l(datain_l), .dataout_h(c_dh), .dataout_l(c_dl),
    .combout(c_cb), .oe_out(c_oe), .padio(pad_c));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic rise(input int d); @(posedge inclock); #(d); endtask
  task automatic fall(input int d); @(negedge inclock); #(d); endtask

  initial begin
    aclr = 1'b1; aset = 1'b0; sclr = 1'b0; sset = 1'b0;
    inclocken = 1'b1; outclocken = 1'b1; oe = 1'b1;
    datain_h = 8'h00; datain_l = 8'h00; ext_en = 1'b0; ext_val = 8'h00;

    rise(0); rise(2);
    chk("rst_dout_h", a_dh, 8'h00);
    chk("rst_dout_l", a_dl, 8'h00);
    chk("rst_oe_out", a_oe, 8'h00);

    fall(1);
    aclr = 1'b0; datain_h = 8'hA5; datain_l = 8'h3C;
    rise(2);
    chk("tx_oe_after_rst", a_oe, 8'hFF);
    chk("tx_high", a_cb, 8'hA5);
    chk("inv_high", b_cb, 8'h5A);
    chk("ext_oe_half_cycle", c_oe, 8'h00);
    fall(2);
    chk("tx_low", a_cb, 8'h3C);
    chk("inv_low", b_cb, 8'hC3);
    chk("ext_oe_asserted", c_oe, 8'hFF);
    #1 oe = 1'b0;

    rise(1);
    ext_en = 1'b1; ext_val = 8'h22;
    #1;
    chk("rx_oe_off", a_oe, 8'h00);
    chk("rx_comb_22", a_cb, 8'h22);
    chk("ext_oe_drop", c_oe, 8'h00);
    fall(1);
    ext_val = 8'h11;
    #1 chk("rx_comb_11", a_cb, 8'h11);
    rise(2);
    chk("rx_dout_h", a_dh, 8'h11);
    chk("rx_dout_l", a_dl, 8'h22);

    #1 inclocken = 1'b0; ext_val = 8'h33;
    fall(1); ext_val = 8'h44;
    rise(2);
    chk("inen_hold_h", a_dh, 8'h11);
    chk("inen_hold_l", a_dl, 8'h22);
    #1 inclocken = 1'b1; ext_val = 8'h55;
    fall(1); ext_val = 8'h66;
    rise(2);
    chk("inen_resume_h", a_dh, 8'h66);
    chk("inen_resume_l", a_dl, 8'h55);

    #1 sset = 1'b1;
    rise(2);
    chk("sset_h", a_dh, 8'hFF);
    chk("sset_l", a_dl, 8'hFF);
    #1 sset = 1'b0; sclr = 1'b1;
    rise(2);
    chk("sclr_h", a_dh, 8'h00);
    chk("sclr_l", a_dl, 8'h00);
    #1 sclr = 1'b0;

    fall(2);
    aset = 1'b1;
    #1;
    chk("aset_h", a_dh, 8'hFF);
    chk("aset_l", a_dl, 8'hFF);
    #1 aset = 1'b0;
    rise(2);
    chk("aset_release_h", a_dh, 8'h66);
    #1 aclr = 1'b1; aset = 1'b1;
    #1;
    chk("aclr_aset_h", a_dh, 8'h00);
    chk("aclr_aset_l", a_dl, 8'h00);
    chk("aclr_aset_oe", a_oe, 8'h00);

    fall(1);
    aclr = 1'b0; aset = 1'b0; ext_en = 1'b0; oe = 1'b1;
    datain_h = 8'h12; datain_l = 8'h34;
    rise(2);
    chk("tx2_oe", a_oe, 8'hFF);
    chk("tx2_high", a_cb, 8'h12);
    fall(2);
    chk("tx2_low", a_cb, 8'h34);
    #1 outclocken = 1'b0; datain_h = 8'h56; datain_l = 8'h78;
    rise(2);
    chk("outen_hold_high", a_cb, 8'h12);
    chk("outen_hold_oe", a_oe, 8'hFF);
    fall(2);
    chk("outen_hold_low", a_cb, 8'h34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
